// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Holds the clock low to request a send, then shifts out one byte plus odd
// parity and stop on the device's clock. The device ACK ends the transfer.
// A shared saturating cycle counter times the inhibit and request phases and
// also acts as the no-response timeout. rst_ni is a synchronous active-low reset.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 480,
  parameter int REQUEST_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 60000,
  parameter int COUNTER_BITS   = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_low_o,
  output logic       ps2_data_low_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_REQUEST  = 3'd2,
    ST_SEND     = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAITIDLE = 3'd5
  } state_e;

  // Comparisons are against "last count" so each phase lasts exactly N cycles.
  localparam logic [COUNTER_BITS-1:0] CNT_ONE      = {{(COUNTER_BITS-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_BITS-1:0] INHIBIT_LAST = COUNTER_BITS'(INHIBIT_CYCLES - 1);
  localparam logic [COUNTER_BITS-1:0] REQUEST_LAST = COUNTER_BITS'(REQUEST_CYCLES - 1);
  localparam logic [COUNTER_BITS-1:0] TIMEOUT_LAST = COUNTER_BITS'(TIMEOUT_CYCLES - 1);

  // Odd parity bit over the data byte.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  state_e                  state_q, state_d;
  logic [COUNTER_BITS-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [9:0]              shift_q, shift_d;
  logic [3:0]              bit_idx_q, bit_idx_d;
  logic                    data_low_q, data_low_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [2:0]              clk_sync_q;   // [0],[1] synchronizer, [2] previous sample
  logic [1:0]              data_sync_q;
  logic                    fall_s, clk_s, data_s, timed_s;

  assign clk_s     = clk_sync_q[1];
  assign data_s    = data_sync_q[1];
  assign fall_s    = clk_sync_q[2] & ~clk_sync_q[1];
  assign cnt_inc_s = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);
  assign timed_s   = (state_q == ST_SEND) || (state_q == ST_ACK) || (state_q == ST_WAITIDLE);

  // Synchronize the raw PS/2 lines and keep one extra clock sample for edge detect.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      clk_sync_q  <= 3'b000;
      data_sync_q <= 2'b00;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  // State register and datapath registers, cleared together by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= 10'd0;
      bit_idx_q  <= 4'd0;
      data_low_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      data_low_q <= data_low_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state and datapath update; timeout overrides every transfer state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc_s;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    data_low_d = data_low_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        data_low_d = 1'b0;
        if (tx_start_i) begin
          state_d   = ST_INHIBIT;
          shift_d   = {1'b1, odd_parity(tx_data_i), tx_data_i};
          bit_idx_d = 4'd0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          state_d    = ST_REQUEST;
          cnt_d      = '0;
          data_low_d = 1'b1;          // start bit
        end else begin
          data_low_d = 1'b0;
        end
      end
      ST_REQUEST: begin
        data_low_d = 1'b1;
        if (cnt_q == REQUEST_LAST) begin
          state_d   = ST_SEND;
          cnt_d     = '0;
          bit_idx_d = 4'd0;
        end else begin
          state_d   = ST_REQUEST;
        end
      end
      ST_SEND: begin
        if (fall_s) begin
          data_low_d = ~shift_q[0];   // index 9 is the stop bit, so the line is released
          shift_d    = {1'b0, shift_q[9:1]};
          bit_idx_d  = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd9) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_ACK: begin
        if (fall_s) begin
          data_low_d = 1'b0;
          if (!data_s) begin
            done_d  = 1'b1;
            state_d = ST_WAITIDLE;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_WAITIDLE: begin
        data_low_d = 1'b0;
        if (clk_s && data_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAITIDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        data_low_d = 1'b0;
      end
    endcase

    if (timed_s && (cnt_q == TIMEOUT_LAST)) begin
      state_d    = ST_IDLE;
      data_low_d = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b1;
    end else begin
      error_d    = error_d;
    end
  end

  // Output decode: clock pull from state, everything else straight from registers.
  always_comb begin
    ps2_clk_low_o  = (state_q == ST_INHIBIT) || (state_q == ST_REQUEST);
    busy_o         = (state_q != ST_IDLE);
    ps2_data_low_o = data_low_q;
    done_o         = done_q;
    error_o        = error_q;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte at a time to the keyboard, such as LED set (0xED) or reset (0xFF). It is the outbound counterpart of the PS/2 receive decoder and shares the same open-collector ps2Clk/ps2Data lines. It runs in the 4 MHz processor clock domain. Its `busy` output tells the receive decoder to ignore line activity while a transmit is in progress.

## Interface
- `inhibitCycles`, default 480: clock cycles ps2Clk is held low to request a send (120 µs at 4 MHz).
- `requestCycles`, default 8: cycles both lines are held low before ps2Clk is released.
- `timeoutCycles`, default 60000: maximum cycles from clock release to ACK (15 ms).
- `counterBits`, default 16: width of the shared cycle counter. It must hold every count above.
- `clk`  in  1: processor clock. Every register is updated on its rising edge.
- `reset`  in  1: synchronous, active-low. While 0, all state is cleared on the next edge.
- `txData`  in  8: byte to send. Sampled when `txStart` is accepted.
- `txStart`  in  1: single-cycle request. Accepted only in IDLE; ignored otherwise.
- `ps2ClkIn`  in  1: raw PS/2 clock line, asynchronous.
- `ps2DataIn`  in  1: raw PS/2 data line, asynchronous.
- `ps2ClkLow`  out  1: 1 = pull ps2Clk low; 0 = release.
- `ps2DataLow`  out  1: 1 = pull ps2Data low; 0 = release.
- `busy`  out  1: high from acceptance until the return to IDLE.
- `done`  out  1: one-cycle pulse when the device ACK is received.
- `error`  out  1: one-cycle pulse on a timeout or a missing ACK.

## Operation
- Both raw inputs pass through a 2-flop synchronizer. A third flop detects falling edges: `fall` = previous 1 and current 0 of the synchronized clock.
- The shift register is 10 bits: {stop=1, parity, txData[7:0]}, sent LSB first. Parity is odd: parity = ~^txData.
- IDLE: both lines released, `busy`=0.
  - When `txStart` is accepted: latch the shift register, clear the counter, go to INHIBIT.
- INHIBIT: `ps2ClkLow`=1. After `inhibitCycles` cycles, go to REQUEST.
- REQUEST: `ps2ClkLow`=1 and `ps2DataLow`=1 (the start bit). After `requestCycles` cycles, release the clock, clear the counter and go to SEND with bitIndex=0.
- SEND: `ps2ClkLow`=0.
  - On each `fall` with bitIndex 0..9, drive `ps2DataLow` = ~shift[0], shift right, then increment bitIndex.
  - Index 9 is the stop bit, so data is released.
  - After index 9 is driven, go to ACK.
- ACK: on the next `fall`, sample the synchronized data.
  - Data = 0: assert `done` and go to WAITIDLE.
  - Data = 1: assert `error` and go to IDLE.
- WAITIDLE: wait until the synchronized clock and data are both 1, then go to IDLE.
- Timeout: the counter runs through SEND, ACK and WAITIDLE.
  - When the counter reaches `timeoutCycles`: pulse `error`, release both lines, go to IDLE.
  - `done` and `error` never assert in the same cycle.
- The counter saturates and never wraps.

## Timing
- Reset (`reset`=0): state IDLE, and every output is 0: `ps2ClkLow`, `ps2DataLow`, `busy`, `done`, `error`.
  - Reset mid-transfer releases both lines on the same edge.
  - A half-sent byte is discarded and is not resumed.
- `txStart` high at edge N:
  - `busy`=1 and `ps2ClkLow`=1 after edge N.
  - `ps2DataLow` rises after edge N+`inhibitCycles`.
  - `ps2ClkLow` falls after edge N+`inhibitCycles`+`requestCycles`.
- Device falling edge to new data on the line: 3 clk cycles (2 sync + 1 edge-detect register). This is far inside the ≥15 µs low phase of the device clock.
- `done` or `error` pulses on the cycle state leaves ACK or timeout. `busy` drops on the edge IDLE is entered.
- `txStart` while `busy`=1 is ignored. A new request can be accepted on the first IDLE cycle.
- A device clock glitch shorter than 2 cycles may be missed. This is acceptable because the device clock is ≥60 cycles per phase.

## Test plan
- Send 0xED, with the device model clocking at 12.5 kHz and giving ACK:
  - Expect clock held low for 480 cycles, then the start bit.
  - Expect bits 1,0,1,1,0,1,1,1, parity 1, stop released.
  - Expect `done` pulse, `busy` low after both lines idle.
- Send 0x01: expect parity bit 0, and `ps2DataLow`=1 during the parity bit time.
- Device never clocks after the request: expect an `error` pulse exactly 60000 cycles after clock release, both lines released, `busy`=0.
- Device clocks 11 falls but leaves data high at the ACK: expect an `error` pulse on the 11th fall and no `done`.
- Assert `reset`=0 during bit 4 of a 0xFF send:
  - Expect both lines released on the next edge and all outputs 0.
  - A following `txStart` of 0x55 completes normally.
- `txStart` pulsed with 0xAA while busy sending 0xF4: expect 0xF4 transmitted unchanged, with the 0xAA request dropped and no second transfer.
